// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the pipelined ARM control unit: ALU ops, op/cmd fields,
// condition codes and the control word carried down the pipeline.
package arm_ctrl_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_control;
    logic       branch;
    logic [1:0] flag_w;      // [1] = NZ, [0] = CV
    logic       pc_src;
    cond_e      cond;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_controller_if.sv
// Datapath-facing signal bundle of the pipelined control unit; the controller
// sits on the slave modport, the datapath/hazard side on the master modport.
interface pipe_controller_if;
  // No handshake: the pipeline advances every clock, FlushE only bubbles E.
  logic [19:0] InstrD;
  logic [3:0]  ALUFlagsE;
  logic        FlushE;
  logic [1:0]  RegSrcD;
  logic [1:0]  ImmSrcD;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic        BranchTakenE;
  logic        MemWriteM;
  logic        MemtoRegW;
  logic        PCSrcW;
  logic        RegWriteW;
  logic        RegWriteM;
  logic        MemtoRegE;
  logic        PCWrPendingF;
  logic [3:0]  flags_dbg;
  logic [1:0]  flag_write_dbg;

  modport master (
    output InstrD, ALUFlagsE, FlushE,
    input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemWriteM,
           MemtoRegW, PCSrcW, RegWriteW, RegWriteM, MemtoRegE, PCWrPendingF,
           flags_dbg, flag_write_dbg
  );

  modport slave (
    input  InstrD, ALUFlagsE, FlushE,
    output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemWriteM,
           MemtoRegW, PCSrcW, RegWriteW, RegWriteM, MemtoRegE, PCWrPendingF,
           flags_dbg, flag_write_dbg
  );
endinterface

// File: rtl/cond_unit.sv
// NZCV flag register plus condition evaluation for the instruction in Execute.
// Flags are read from the register only; a flag update is visible next cycle.
module cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  cond_e      CondE,
  input  logic [3:0] ALUFlagsE,
  input  logic [1:0] FlagWE,
  output logic       CondExE,
  output logic [1:0] FlagWriteEn,
  output logic [3:0] flags_dbg
);

  logic [3:0] flags;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    CondExE = 1'b0;
    case (CondE)
      COND_EQ: CondExE = z;
      COND_NE: CondExE = ~z;
      COND_CS: CondExE = c;
      COND_CC: CondExE = ~c;
      COND_MI: CondExE = n;
      COND_PL: CondExE = ~n;
      COND_VS: CondExE = v;
      COND_VC: CondExE = ~v;
      COND_HI: CondExE = c & ~z;
      COND_LS: CondExE = ~c | z;
      COND_GE: CondExE = (n == v);
      COND_LT: CondExE = (n != v);
      COND_GT: CondExE = ~z & (n == v);
      COND_LE: CondExE = z | (n != v);
      COND_AL: CondExE = 1'b1;
      COND_NV: CondExE = 1'b0;
    endcase
  end

  assign FlagWriteEn = FlagWE & {2{CondExE}};
  assign flags_dbg   = flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 4'b0000;
    end else begin
      if (FlagWriteEn[1]) flags[3:2] <= ALUFlagsE[3:2];
      if (FlagWriteEn[0]) flags[1:0] <= ALUFlagsE[1:0];
    end
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined ARM control unit: decodes in D, carries the control word through
// E/M/W, gates side effects with the Execute condition result.
module pipe_controller
  import arm_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  pipe_controller_if.slave   bus
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       unused_rn;

  ctrl_t      ctrl_d;
  ctrl_t      ctrl_e;
  logic [1:0] reg_src_d;
  logic [1:0] imm_src_d;

  logic       cond_ex_e;
  logic       reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m;
  logic       reg_write_w, mem_to_reg_w, pc_src_w;

  assign op        = bus.InstrD[15:14];
  assign funct     = bus.InstrD[13:8];
  assign cmd       = funct[4:1];
  assign rd        = bus.InstrD[3:0];
  assign unused_rn = ^bus.InstrD[7:4];

  always_comb begin
    ctrl_d      = CTRL_NOP;
    reg_src_d   = 2'b00;
    imm_src_d   = 2'b00;
    ctrl_d.cond = cond_e'(bus.InstrD[19:16]);
    case (op)
      OP_DP: begin
        ctrl_d.reg_w   = 1'b1;
        ctrl_d.alu_src = funct[5];
        case (cmd)
          CMD_ADD: ctrl_d.alu_control = ALU_ADD;
          CMD_SUB: ctrl_d.alu_control = ALU_SUB;
          CMD_AND: ctrl_d.alu_control = ALU_AND;
          CMD_ORR: ctrl_d.alu_control = ALU_ORR;
          CMD_CMP: begin
            ctrl_d.alu_control = ALU_SUB;
            ctrl_d.reg_w       = 1'b0;
          end
          default: ctrl_d.alu_control = ALU_ADD;
        endcase
        ctrl_d.flag_w[1] = funct[0];
        ctrl_d.flag_w[0] = funct[0] &
                           ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
        if (cmd == CMD_CMP) ctrl_d.flag_w = 2'b11;
      end
      OP_MEM: begin
        ctrl_d.alu_src     = 1'b1;
        ctrl_d.alu_control = ALU_ADD;
        imm_src_d          = 2'b01;
        if (funct[0]) begin
          ctrl_d.reg_w      = 1'b1;
          ctrl_d.mem_to_reg = 1'b1;
        end else begin
          ctrl_d.mem_w = 1'b1;
          reg_src_d    = 2'b10;
        end
      end
      OP_BR: begin
        ctrl_d.branch      = 1'b1;
        ctrl_d.alu_src     = 1'b1;
        ctrl_d.alu_control = ALU_ADD;
        imm_src_d          = 2'b10;
        reg_src_d          = 2'b01;
      end
      default: ;
    endcase
    // Branches redirect through BranchTakenE, so only register writes to R15 count here.
    ctrl_d.pc_src = ctrl_d.reg_w & (rd == 4'hF);
  end

  cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .CondE       (ctrl_e.cond),
    .ALUFlagsE   (bus.ALUFlagsE),
    .FlagWE      (ctrl_e.flag_w),
    .CondExE     (cond_ex_e),
    .FlagWriteEn (bus.flag_write_dbg),
    .flags_dbg   (bus.flags_dbg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e       <= CTRL_NOP;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      pc_src_m     <= 1'b0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      pc_src_w     <= 1'b0;
    end else begin
      ctrl_e       <= bus.FlushE ? CTRL_NOP : ctrl_d;
      reg_write_m  <= ctrl_e.reg_w  & cond_ex_e;
      mem_write_m  <= ctrl_e.mem_w  & cond_ex_e;
      pc_src_m     <= ctrl_e.pc_src & cond_ex_e;
      mem_to_reg_m <= ctrl_e.mem_to_reg;
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      pc_src_w     <= pc_src_m;
    end
  end

  assign bus.RegSrcD      = reg_src_d;
  assign bus.ImmSrcD      = imm_src_d;
  assign bus.ALUSrcE      = ctrl_e.alu_src;
  assign bus.ALUControlE  = ctrl_e.alu_control;
  assign bus.BranchTakenE = ctrl_e.branch & cond_ex_e;
  assign bus.MemtoRegE    = ctrl_e.mem_to_reg;
  assign bus.MemWriteM    = mem_write_m;
  assign bus.RegWriteM    = reg_write_m;
  assign bus.MemtoRegW    = mem_to_reg_w;
  assign bus.PCSrcW       = pc_src_w;
  assign bus.RegWriteW    = reg_write_w;
  // The E-stage term is unconditioned so fetch stalls before the condition resolves.
  assign bus.PCWrPendingF = ctrl_d.pc_src | ctrl_e.pc_src | pc_src_m;

endmodule
